uart_word_rx: RTL and testbench

Serial input stage that feeds the 12-bit input FIFO. It receives 8N1 UART bytes on a single pin and packs each pair of bytes into one 12-bit word. It presents each word on `data_in` with a one-cycle `data_write` strobe, which connects directly to the FIFO's write port. It detects framing errors and discards a stale half-word after a line-idle timeout.

---
 rtl/uart_word_rx.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_word_rx.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_rx.sv
// uart_word_rx: 8N1 UART receiver that packs each pair of bytes into one 12-bit FIFO word.
// The low byte arrives first; only the lower nibble of the high byte is kept (bits [11:8]).
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        data_write,
  output logic [11:0] data_in,
  output logic        frame_err
);

  localparam int CW        = $clog2(CLKS_PER_BIT);
  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW        = $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic          r_sync1;
  logic          r_sync2;
  logic          w_rx_s;
  logic [CW-1:0] r_bit_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_lo;
  logic          r_phase;
  logic [TW-1:0] r_to_cnt;
  logic [1:0]    r_fill;
  logic          r_armed;
  logic          r_data_write;
  logic          r_frame_err;
  logic [11:0]   r_data_in;
  logic          w_sample_bit;
  logic          w_accept;
  logic          w_bad_stop;
  logic          w_start;
  logic          w_timeout;

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // The synchronizer resets high, so a line held low across reset would look like a
  // fresh falling edge; starts are ignored until the real line has been seen high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill  <= 2'd0;
      r_armed <= 1'b0;
    end else begin
      if (r_fill != 2'd2) begin
        r_fill <= r_fill + 2'd1;
      end else begin
        r_fill <= r_fill;
      end
      if (r_fill == 2'd2 && w_rx_s) begin
        r_armed <= 1'b1;
      end else begin
        r_armed <= r_armed;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_sample_bit = 1'b0;
    w_accept     = 1'b0;
    w_bad_stop   = 1'b0;
    w_start      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_armed && !w_rx_s) begin
          w_start      = 1'b1;
          w_next_state = S_START;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_START: begin
        if (r_bit_cnt == HALF_LAST) begin
          if (!w_rx_s) begin
            w_next_state = S_DATA;
          end else begin
            w_next_state = S_IDLE;
          end
        end else begin
          w_next_state = S_START;
        end
      end
      S_DATA: begin
        if (r_bit_cnt == BIT_LAST) begin
          w_sample_bit = 1'b1;
          if (r_bit_idx == 3'd7) begin
            w_next_state = S_STOP;
          end else begin
            w_next_state = S_DATA;
          end
        end else begin
          w_next_state = S_DATA;
        end
      end
      S_STOP: begin
        if (r_bit_cnt == BIT_LAST) begin
          if (w_rx_s) begin
            w_accept     = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_bad_stop   = 1'b1;
            w_next_state = S_WAIT_HIGH;
          end
        end else begin
          w_next_state = S_STOP;
        end
      end
      S_WAIT_HIGH: begin
        if (w_rx_s) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_WAIT_HIGH;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // A start bit seen in the expiry cycle wins, keeping the pending low byte.
  assign w_timeout = (r_state == S_IDLE) && r_phase && (r_to_cnt == TO_LAST) && !w_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= {CW{1'b0}};
    end else if ((w_next_state != r_state) || (r_state == S_IDLE) || (r_state == S_WAIT_HIGH)) begin
      r_bit_cnt <= {CW{1'b0}};
    end else if (r_bit_cnt == BIT_LAST) begin
      r_bit_cnt <= {CW{1'b0}};
    end else begin
      r_bit_cnt <= r_bit_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else if (w_sample_bit) begin
      r_bit_idx <= r_bit_idx + 3'd1;
      r_shift   <= {w_rx_s, r_shift[7:1]};
    end else if (r_state != S_DATA) begin
      r_bit_idx <= 3'd0;
    end else begin
      r_bit_idx <= r_bit_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= {TW{1'b0}};
    end else if ((r_state == S_IDLE) && r_phase && !w_start && !w_timeout) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end else begin
      r_to_cnt <= {TW{1'b0}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase      <= 1'b0;
      r_lo         <= 8'h00;
      r_data_in    <= 12'h000;
      r_data_write <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_data_write <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_accept) begin
        if (r_phase) begin
          r_data_in    <= {r_shift[3:0], r_lo};
          r_data_write <= 1'b1;
          r_phase      <= 1'b0;
        end else begin
          r_lo    <= r_shift;
          r_phase <= 1'b1;
        end
      end else if (w_bad_stop) begin
        r_frame_err <= 1'b1;
        r_phase     <= 1'b0;
      end else if (w_timeout) begin
        r_phase <= 1'b0;
        r_lo    <= 8'h00;
      end else begin
        r_phase <= r_phase;
      end
    end
  end

  assign data_write = r_data_write;
  assign data_in    = r_data_in;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_uart_word_rx.sv
// tb_uart_word_rx: drives 8N1 frames into uart_word_rx and compares every strobe and
// framing-error pulse (value and cycle) against an event-level model of the byte pairing.
module tb_uart_word_rx;

  localparam int CPB = 16;
  localparam int TOB = 4;
  localparam int NTO = CPB * TOB;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

  typedef struct packed {
    int unsigned cyc;
    logic        err;
    logic [11:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        data_write;
  logic        frame_err;
  logic [11:0] data_in;
  logic [11:0] prev_data = 12'h000;

  int unsigned cyc = 0;
  int          vectors = 0;
  int          fails = 0;
  int          stab_err = 0;
  ev_t         got_q[$];
  ev_t         exp_q[$];

  logic        m_phase;
  logic [7:0]  m_lo;
  int unsigned m_idle_at;

  uart_word_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .data_write(data_write), .data_in(data_in), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (data_write) got_q.push_back(ev_t'{cyc, 1'b0, data_in});
      if (frame_err) got_q.push_back(ev_t'{cyc, 1'b1, 12'h000});
      if (!data_write && (data_in !== prev_data)) stab_err <= stab_err + 1;
    end
    prev_data <= data_in;
  end

  // Frame whose start edge reaches the pin at cycle c: pairing, timeout and error rules.
  task automatic model_frame(input int unsigned c, input logic [7:0] b, input logic stop_ok);
    if (m_phase && (c + 2 > m_idle_at + NTO)) m_phase = 1'b0;
    if (!stop_ok) begin
      m_phase = 1'b0;
      exp_q.push_back(ev_t'{c + LAT, 1'b1, 12'h000});
    end else if (!m_phase) begin
      m_lo      = b;
      m_phase   = 1'b1;
      m_idle_at = c + LAT;
    end else begin
      exp_q.push_back(ev_t'{c + LAT, 1'b0, {b[3:0], m_lo}});
      m_phase = 1'b0;
    end
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int hold_low, input int gap);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    model_frame(cyc, b, stop_ok);
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    if (hold_low > 0) begin
      repeat (hold_low) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    m_phase = 1'b0;
    m_lo = 8'h00;
    m_idle_at = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (data_write !== 1'b0) begin fails++; $display("FAIL reset_data_write: got %b, expected 0", data_write); end
    vectors++;
    if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
    vectors++;
    if (data_in !== 12'h000) begin fails++; $display("FAIL reset_data_in: got %h, expected 000", data_in); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_basic_word;
    send_frame(8'h34, 1'b1, 0, 0);
    send_frame(8'h12, 1'b1, 0, 10);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL basic_count: got %0d events, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL basic_ev%0d: got cyc=%0d err=%b data=%h, expected cyc=%0d err=%b data=%h",
                 i, got_q[i].cyc, got_q[i].err, got_q[i].data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_streaming;
    logic [7:0] seq [6];
    seq = '{8'hFF, 8'hFF, 8'h00, 8'hA0, 8'h5A, 8'h0C};
    for (int i = 0; i < 6; i++) send_frame(seq[i], 1'b1, 0, (i == 5) ? 10 : 0);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL stream_count: got %0d events, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL stream_ev%0d: got cyc=%0d err=%b data=%h, expected cyc=%0d err=%b data=%h",
                 i, got_q[i].cyc, got_q[i].err, got_q[i].data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_frame_err;
    send_frame(8'h34, 1'b0, 40, 20);
    send_frame(8'h78, 1'b1, 0, 0);
    send_frame(8'h01, 1'b1, 0, 10);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL ferr_count: got %0d events, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL ferr_ev%0d: got cyc=%0d err=%b data=%h, expected cyc=%0d err=%b data=%h",
                 i, got_q[i].cyc, got_q[i].err, got_q[i].data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // The frame after the glitch starts so that its start is seen CPB/2+3 cycles after the glitch.
  task automatic test_glitch;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (CPB / 2 + 3 - 4) @(posedge clk);
    #1;
    send_frame(8'h9C, 1'b1, 0, 0);
    send_frame(8'h4B, 1'b1, 0, 10);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL glitch_count: got %0d events, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL glitch_ev%0d: got cyc=%0d err=%b data=%h, expected cyc=%0d err=%b data=%h",
                 i, got_q[i].cyc, got_q[i].err, got_q[i].data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Gaps of 57/58 idle cycles put the next start exactly on / one past the expiry cycle.
  task automatic test_timeout;
    send_frame(8'h11, 1'b1, 0, 70);
    send_frame(8'h22, 1'b1, 0, 0);
    send_frame(8'h03, 1'b1, 0, 10);
    send_frame(8'hA5, 1'b1, 0, 57);
    send_frame(8'h0B, 1'b1, 0, 10);
    send_frame(8'h3C, 1'b1, 0, 58);
    send_frame(8'h44, 1'b1, 0, 0);
    send_frame(8'h05, 1'b1, 0, 10);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL timeout_count: got %0d events, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL timeout_ev%0d: got cyc=%0d err=%b data=%h, expected cyc=%0d err=%b data=%h",
                 i, got_q[i].cyc, got_q[i].err, got_q[i].data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random;
    logic [7:0] b;
    logic       ok;
    int         g;
    int         h;
    int         sel;
    for (int n = 0; n < 20; n++) begin
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 7) != 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       g = 0;
        1:       g = $urandom_range(1, 40);
        2:       g = $urandom_range(80, 120);
        default: g = $urandom_range(0, 100);
      endcase
      h = 0;
      if (!ok) begin
        h = $urandom_range(0, 30);
        if (g < 2) g = 2;
      end
      send_frame(b, ok, h, g);
    end
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL random_count: got %0d events, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL random_ev%0d: got cyc=%0d err=%b data=%h, expected cyc=%0d err=%b data=%h",
                 i, got_q[i].cyc, got_q[i].err, got_q[i].data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Second byte is 0x00 so the line stays low across reset release until its stop bit.
  task automatic test_reset_mid;
    rx = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    send_frame(8'h55, 1'b1, 0, 0);
    rx = 1'b0;
    repeat (5 * CPB + CPB / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    m_phase = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({data_write, frame_err, data_in} !== 14'h0000) begin
        fails++;
        $display("FAIL midreset_outputs%0d: got write=%b err=%b data=%h, expected 0 0 000", k, data_write, frame_err, data_in);
      end
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    repeat (9 * CPB - (5 * CPB + CPB / 2) - 3) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    send_frame(8'h66, 1'b1, 0, 0);
    send_frame(8'h07, 1'b1, 0, 10);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      fails++; $display("FAIL midreset_count: got %0d events, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL midreset_ev%0d: got cyc=%0d err=%b data=%h, expected cyc=%0d err=%b data=%h",
                 i, got_q[i].cyc, got_q[i].err, got_q[i].data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data);
      end
    end
    got_q.delete();
    exp_q.delete();
    vectors++;
    if (stab_err !== 0) begin
      fails++; $display("FAIL data_in_stability: got %0d changes without a strobe, expected 0", stab_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_streaming();
    test_frame_err();
    test_glitch();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
